// File: rtl/mem_if_pkg.sv
// Shared memory-interface definitions: opcodes, bus widths and arbiter states.
package mem_if_pkg;

    localparam int unsigned MEM_ADDR_W = 24;
    localparam int unsigned MEM_DATA_W = 8;

    localparam logic [1:0] OP_RD_KEY  = 2'b00;
    localparam logic [1:0] OP_RD_TEXT = 2'b01;
    localparam logic [1:0] OP_WR_RES  = 2'b10;
    localparam logic [1:0] OP_RDSR    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_BUSY
    } arb_state_t;

endpackage

// File: rtl/mem_rr_arbiter.sv
// Combinational round-robin winner select, searching upward from last_grant+1.
// MEM_ARB_KEY_PRIO_EN: requester 0 overrides the rotation whenever it requests.
module mem_rr_arbiter #(
    parameter int unsigned NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       gnt_any
);

    logic [NUM_REQ-1:0] rr_req;
    int unsigned        idx;

    always_comb begin
        rr_req  = req;
        gnt     = '0;
        gnt_any = 1'b0;
        idx     = 0;
`ifdef MEM_ARB_KEY_PRIO_EN
        rr_req[0] = 1'b0;
        if (req[0]) begin
            gnt[0]  = 1'b1;
            gnt_any = 1'b1;
        end
`endif
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = 32'(last_grant) + i;
            if (idx >= NUM_REQ)
                idx = idx - NUM_REQ;
            if (!gnt_any && rr_req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_cmd_arbiter.sv
// Shares the memory transaction FSM command/data port among NUM_REQ requesters.
// Optional build macro MEM_ARB_KEY_PRIO_EN gives requester 0 strict priority.
module mem_cmd_arbiter
    import mem_if_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 3,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [2*NUM_REQ-1:0]              req_opcode,
    input  logic [MEM_ADDR_W*NUM_REQ-1:0]     req_addr,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ-1:0]                req_wdata_valid,
    input  logic [MEM_DATA_W*NUM_REQ-1:0]     req_wdata,
    output logic [NUM_REQ-1:0]                req_wdata_ready,
    output logic [NUM_REQ-1:0]                req_rdata_valid,
    output logic [MEM_DATA_W-1:0]             req_rdata,
    input  logic [NUM_REQ-1:0]                req_rdata_ready,
    output logic [NUM_REQ-1:0]                req_done,
    output logic                              req_err,
    output logic                              fsm_cmd_valid,
    output logic [1:0]                        fsm_cmd_opcode,
    output logic [MEM_ADDR_W-1:0]             fsm_cmd_addr,
    input  logic                              fsm_cmd_ready,
    output logic                              fsm_wr_data_valid,
    output logic [MEM_DATA_W-1:0]             fsm_wr_data,
    input  logic                              fsm_data_ready,
    input  logic                              fsm_rd_valid,
    input  logic [MEM_DATA_W-1:0]             fsm_rd_data,
    output logic                              fsm_rd_ready,
    input  logic                              op_done,
    output logic [$clog2(NUM_REQ)-1:0]        grant_id,
    output logic                              arb_busy
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    arb_state_t              state_q, state_d;
    logic [IDX_W-1:0]        last_q, last_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0]      arb_gnt;
    logic                    arb_any;
    logic [IDX_W-1:0]        arb_idx;

    logic                    cmd_valid_d;
    logic [1:0]              opcode_d;
    logic [MEM_ADDR_W-1:0]   addr_d;
    logic [IDX_W-1:0]        grant_d;
    logic                    busy_d;
    logic [NUM_REQ-1:0]      ready_d;
    logic [NUM_REQ-1:0]      done_d;
    logic                    err_d;

    mem_rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_arbiter (
        .req        (req_valid),
        .last_grant (last_q),
        .gnt        (arb_gnt),
        .gnt_any    (arb_any)
    );

    always_comb begin
        arb_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++)
            if (arb_gnt[i])
                arb_idx = IDX_W'(i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            last_q         <= IDX_W'(NUM_REQ - 1);
            cnt_q          <= '0;
            fsm_cmd_valid  <= 1'b0;
            fsm_cmd_opcode <= '0;
            fsm_cmd_addr   <= '0;
            grant_id       <= '0;
            arb_busy       <= 1'b0;
            req_ready      <= '0;
            req_done       <= '0;
            req_err        <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_q         <= last_d;
            cnt_q          <= cnt_d;
            fsm_cmd_valid  <= cmd_valid_d;
            fsm_cmd_opcode <= opcode_d;
            fsm_cmd_addr   <= addr_d;
            grant_id       <= grant_d;
            arb_busy       <= busy_d;
            req_ready      <= ready_d;
            req_done       <= done_d;
            req_err        <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        cmd_valid_d = fsm_cmd_valid;
        opcode_d    = fsm_cmd_opcode;
        addr_d      = fsm_cmd_addr;
        grant_d     = grant_id;
        busy_d      = arb_busy;
        ready_d     = '0;
        done_d      = '0;
        err_d       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    opcode_d    = req_opcode[2*arb_idx +: 2];
                    addr_d      = req_addr[MEM_ADDR_W*arb_idx +: MEM_ADDR_W];
                    grant_d     = arb_idx;
                    busy_d      = 1'b1;
                    cmd_valid_d = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (fsm_cmd_ready) begin
                    ready_d[grant_id] = 1'b1;
                    cmd_valid_d       = 1'b0;
                    cnt_d             = '0;
                    state_d           = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // op_done takes precedence over a coincident timeout
                if (op_done || cnt_q == TO_LAST) begin
                    done_d[grant_id] = 1'b1;
                    err_d            = !op_done;
                    busy_d           = 1'b0;
                    state_d          = ST_IDLE;
`ifdef MEM_ARB_KEY_PRIO_EN
                    if (grant_id != '0)
                        last_d = grant_id;
`else
                    last_d = grant_id;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fsm_wr_data_valid = 1'b0;
        fsm_wr_data       = '0;
        req_wdata_ready   = '0;
        req_rdata_valid   = '0;
        req_rdata         = '0;
        fsm_rd_ready      = 1'b0;
        if (state_q == ST_BUSY) begin
            fsm_wr_data_valid         = req_wdata_valid[grant_id];
            fsm_wr_data               = req_wdata[MEM_DATA_W*grant_id +: MEM_DATA_W];
            req_wdata_ready[grant_id] = fsm_data_ready;
            req_rdata_valid[grant_id] = fsm_rd_valid;
            req_rdata                 = fsm_rd_data;
            fsm_rd_ready              = req_rdata_ready[grant_id];
        end
    end

endmodule

// File: tb/tb_mem_cmd_arbiter.sv
// Directed bench for mem_cmd_arbiter (NUM_REQ=3, TIMEOUT_CYC=16).
module tb_mem_cmd_arbiter;
    import mem_if_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [5:0]  req_opcode;
    logic [71:0] req_addr;
    logic [2:0]  req_ready;
    logic [2:0]  req_wdata_valid;
    logic [23:0] req_wdata;
    logic [2:0]  req_wdata_ready;
    logic [2:0]  req_rdata_valid;
    logic [7:0]  req_rdata;
    logic [2:0]  req_rdata_ready;
    logic [2:0]  req_done;
    logic        req_err;
    logic        fsm_cmd_valid;
    logic [1:0]  fsm_cmd_opcode;
    logic [23:0] fsm_cmd_addr;
    logic        fsm_cmd_ready;
    logic        fsm_wr_data_valid;
    logic [7:0]  fsm_wr_data;
    logic        fsm_data_ready;
    logic        fsm_rd_valid;
    logic [7:0]  fsm_rd_data;
    logic        fsm_rd_ready;
    logic        op_done;
    logic [1:0]  grant_id;
    logic        arb_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_cmd_arbiter #(
        .NUM_REQ     (3),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_opcode        (req_opcode),
        .req_addr          (req_addr),
        .req_ready         (req_ready),
        .req_wdata_valid   (req_wdata_valid),
        .req_wdata         (req_wdata),
        .req_wdata_ready   (req_wdata_ready),
        .req_rdata_valid   (req_rdata_valid),
        .req_rdata         (req_rdata),
        .req_rdata_ready   (req_rdata_ready),
        .req_done          (req_done),
        .req_err           (req_err),
        .fsm_cmd_valid     (fsm_cmd_valid),
        .fsm_cmd_opcode    (fsm_cmd_opcode),
        .fsm_cmd_addr      (fsm_cmd_addr),
        .fsm_cmd_ready     (fsm_cmd_ready),
        .fsm_wr_data_valid (fsm_wr_data_valid),
        .fsm_wr_data       (fsm_wr_data),
        .fsm_data_ready    (fsm_data_ready),
        .fsm_rd_valid      (fsm_rd_valid),
        .fsm_rd_data       (fsm_rd_data),
        .fsm_rd_ready      (fsm_rd_ready),
        .op_done           (op_done),
        .grant_id          (grant_id),
        .arb_busy          (arb_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid       = '0;
        req_opcode      = '0;
        req_addr        = '0;
        req_wdata_valid = '0;
        req_wdata       = '0;
        req_rdata_ready = '0;
        fsm_cmd_ready   = 1'b0;
        fsm_data_ready  = 1'b0;
        fsm_rd_valid    = 1'b0;
        fsm_rd_data     = '0;
        op_done         = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        step();
        step();
        rst_n = 1'b1;
    endtask

    // From ISSUE: accept the command, then complete it on the next BUSY cycle.
    task automatic accept_and_finish();
        fsm_cmd_ready = 1'b1;
        step();
        fsm_cmd_ready = 1'b0;
        op_done       = 1'b1;
        step();
        op_done       = 1'b0;
        req_valid     = '0;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        #1;
        n_checks++;
        if ({fsm_cmd_valid, arb_busy, req_ready, req_done, req_err, grant_id} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got valid=%b busy=%b rdy=%b done=%b err=%b gid=%0d exp all 0",
                     fsm_cmd_valid, arb_busy, req_ready, req_done, req_err, grant_id);
        end
        step();
        step();
        rst_n = 1'b1;
        n_checks++;
        if ({fsm_cmd_addr, fsm_cmd_opcode, fsm_rd_ready, fsm_wr_data_valid} !== 28'b0) begin
            n_fail++;
            $display("FAIL reset_cmd_bus got addr=%h op=%b rdr=%b wdv=%b exp 0",
                     fsm_cmd_addr, fsm_cmd_opcode, fsm_rd_ready, fsm_wr_data_valid);
        end
    endtask

    task automatic test_ignore_idle();
        op_done       = 1'b1;
        fsm_cmd_ready = 1'b1;
        step();
        op_done       = 1'b0;
        fsm_cmd_ready = 1'b0;
        n_checks++;
        if ({req_done, req_ready, arb_busy, fsm_cmd_valid} !== 8'b0) begin
            n_fail++;
            $display("FAIL ignore_idle got done=%b rdy=%b busy=%b cv=%b exp 0",
                     req_done, req_ready, arb_busy, fsm_cmd_valid);
        end
    endtask

    task automatic test_single();
        req_valid          = 3'b010;
        req_opcode[3:2]    = OP_RD_TEXT;
        req_addr[47:24]    = 24'h00ABCD;
        req_addr[23:0]     = 24'h111111;
        step();
        req_valid = '0;
        n_checks++;
        if ({fsm_cmd_valid, fsm_cmd_addr, fsm_cmd_opcode, grant_id, arb_busy} !== {1'b1, 24'h00ABCD, 2'b01, 2'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL single_issue got cv=%b addr=%h op=%b gid=%0d busy=%b exp 1 00abcd 01 1 1",
                     fsm_cmd_valid, fsm_cmd_addr, fsm_cmd_opcode, grant_id, arb_busy);
        end
        op_done = 1'b1;
        step();
        op_done = 1'b0;
        n_checks++;
        if ({fsm_cmd_valid, fsm_cmd_addr, req_done, req_ready} !== {1'b1, 24'h00ABCD, 6'b0}) begin
            n_fail++;
            $display("FAIL single_hold got cv=%b addr=%h done=%b rdy=%b exp 1 00abcd 000 000",
                     fsm_cmd_valid, fsm_cmd_addr, req_done, req_ready);
        end
        fsm_cmd_ready = 1'b1;
        step();
        fsm_cmd_ready = 1'b0;
        n_checks++;
        if ({req_ready, fsm_cmd_valid} !== {3'b010, 1'b0}) begin
            n_fail++;
            $display("FAIL single_ready got rdy=%b cv=%b exp 010 0", req_ready, fsm_cmd_valid);
        end
        step();
        n_checks++;
        if (req_ready !== 3'b000) begin
            n_fail++;
            $display("FAIL single_ready_pulse got %b exp 000", req_ready);
        end
        op_done = 1'b1;
        step();
        op_done = 1'b0;
        n_checks++;
        if ({req_done, req_err, arb_busy, grant_id} !== {3'b010, 1'b0, 1'b0, 2'd1}) begin
            n_fail++;
            $display("FAIL single_done got done=%b err=%b busy=%b gid=%0d exp 010 0 0 1",
                     req_done, req_err, arb_busy, grant_id);
        end
        step();
        n_checks++;
        if (req_done !== 3'b000) begin
            n_fail++;
            $display("FAIL single_done_pulse got %b exp 000", req_done);
        end
    endtask

    task automatic test_fairness();
        logic [1:0] exp_g [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
        apply_reset();
        req_valid = 3'b111;
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++;
            if ({grant_id, fsm_cmd_valid} !== {exp_g[k], 1'b1}) begin
                n_fail++;
                $display("FAIL fair_grant[%0d] got gid=%0d cv=%b exp %0d 1", k, grant_id, fsm_cmd_valid, exp_g[k]);
            end
            fsm_cmd_ready = 1'b1;
            step();
            fsm_cmd_ready = 1'b0;
            for (int c = 0; c < 9; c++)
                step();
            op_done = 1'b1;
            step();
            op_done = 1'b0;
            n_checks++;
            if (req_done !== (3'b001 << exp_g[k])) begin
                n_fail++;
                $display("FAIL fair_done[%0d] got %b exp %b", k, req_done, 3'b001 << exp_g[k]);
            end
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_key_prio();
        apply_reset();
        req_valid = 3'b101;
        for (int k = 0; k < 2; k++) begin
            step();
            n_checks++;
            if (grant_id !== 2'd0) begin
                n_fail++;
                $display("FAIL prio_grant[%0d] got %0d exp 0", k, grant_id);
            end
            fsm_cmd_ready = 1'b1;
            step();
            fsm_cmd_ready = 1'b0;
            op_done = 1'b1;
            step();
            op_done = 1'b0;
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_write_path();
        req_valid = 3'b100;
        step();
        req_valid       = '0;
        fsm_data_ready  = 1'b1;
        req_wdata_valid = 3'b111;
        req_wdata       = {8'h5A, 8'h11, 8'h22};
        #1;
        n_checks++;
        if ({req_wdata_ready, fsm_wr_data_valid} !== 4'b0) begin
            n_fail++;
            $display("FAIL wr_issue_blocked got wrdy=%b wdv=%b exp 000 0", req_wdata_ready, fsm_wr_data_valid);
        end
        fsm_cmd_ready = 1'b1;
        step();
        fsm_cmd_ready = 1'b0;
        n_checks++;
        if ({fsm_wr_data_valid, fsm_wr_data, req_wdata_ready} !== {1'b1, 8'h5A, 3'b100}) begin
            n_fail++;
            $display("FAIL wr_route got wdv=%b wd=%h wrdy=%b exp 1 5a 100",
                     fsm_wr_data_valid, fsm_wr_data, req_wdata_ready);
        end
        req_wdata_valid = 3'b011;
        fsm_data_ready  = 1'b0;
        #1;
        n_checks++;
        if ({fsm_wr_data_valid, req_wdata_ready} !== 4'b0) begin
            n_fail++;
            $display("FAIL wr_others_ignored got wdv=%b wrdy=%b exp 0 000", fsm_wr_data_valid, req_wdata_ready);
        end
        req_wdata_valid = '0;
        op_done = 1'b1;
        step();
        op_done = 1'b0;
        step();
    endtask

    task automatic test_read_path();
        req_valid = 3'b001;
        step();
        req_valid = '0;
        fsm_cmd_ready = 1'b1;
        step();
        fsm_cmd_ready   = 1'b0;
        fsm_rd_valid    = 1'b1;
        fsm_rd_data     = 8'hC3;
        req_rdata_ready = 3'b110;
        #1;
        n_checks++;
        if ({req_rdata_valid, req_rdata, fsm_rd_ready, grant_id} !== {3'b001, 8'hC3, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL rd_route got rv=%b rd=%h rdr=%b gid=%0d exp 001 c3 0 0",
                     req_rdata_valid, req_rdata, fsm_rd_ready, grant_id);
        end
        req_rdata_ready = 3'b001;
        #1;
        n_checks++;
        if (fsm_rd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_ready_follow got %b exp 1", fsm_rd_ready);
        end
        fsm_rd_valid    = 1'b0;
        req_rdata_ready = '0;
        op_done = 1'b1;
        step();
        op_done = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        logic early;
        req_valid = 3'b010;
        step();
        req_valid = '0;
        fsm_cmd_ready = 1'b1;
        step();
        fsm_cmd_ready = 1'b0;
        early = 1'b0;
        for (int k = 1; k < 16; k++) begin
            step();
            if (req_done !== 3'b000 || req_err !== 1'b0)
                early = 1'b1;
        end
        n_checks++;
        if (early !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early got early=%b exp 0", early);
        end
        step();
        n_checks++;
        if ({req_done, req_err, arb_busy} !== {3'b010, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL timeout_abort got done=%b err=%b busy=%b exp 010 1 0", req_done, req_err, arb_busy);
        end
        step();
        n_checks++;
        if ({req_done, req_err} !== 4'b0) begin
            n_fail++;
            $display("FAIL timeout_pulse got done=%b err=%b exp 000 0", req_done, req_err);
        end
        req_valid = 3'b100;
        step();
        req_valid = '0;
        fsm_cmd_ready = 1'b1;
        step();
        fsm_cmd_ready = 1'b0;
        for (int k = 1; k < 16; k++)
            step();
        op_done = 1'b1;
        step();
        op_done = 1'b0;
        n_checks++;
        if ({req_done, req_err} !== {3'b100, 1'b0}) begin
            n_fail++;
            $display("FAIL timeout_opdone_wins got done=%b err=%b exp 100 0", req_done, req_err);
        end
        step();
    endtask

    task automatic test_reset_mid();
        req_valid = 3'b001;
        step();
        accept_and_finish();
        req_valid = 3'b010;
        step();
        req_valid = '0;
        fsm_cmd_ready = 1'b1;
        step();
        fsm_cmd_ready = 1'b0;
        step();
        #2;
        rst_n   = 1'b0;
        op_done = 1'b1;
        #1;
        n_checks++;
        if ({arb_busy, fsm_cmd_valid, grant_id, req_ready, req_done} !== 10'b0) begin
            n_fail++;
            $display("FAIL rst_mid_async got busy=%b cv=%b gid=%0d rdy=%b done=%b exp 0",
                     arb_busy, fsm_cmd_valid, grant_id, req_ready, req_done);
        end
        step();
        n_checks++;
        if (req_done !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_mid_no_done got %b exp 000", req_done);
        end
        op_done   = 1'b0;
        rst_n     = 1'b1;
        req_valid = 3'b111;
        step();
        n_checks++;
        if ({grant_id, fsm_cmd_valid} !== {2'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_mid_first_grant got gid=%0d cv=%b exp 0 1", grant_id, fsm_cmd_valid);
        end
        accept_and_finish();
    endtask

    initial begin
        test_reset();
        test_ignore_idle();
        test_single();
`ifdef MEM_ARB_KEY_PRIO_EN
        test_key_prio();
`else
        test_fairness();
`endif
        test_write_path();
        test_read_path();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
